// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read-port register file.
//   state_t   : sweep controller states
//   MIN_RD/MAX_RD : legal range of read-port count
//   slice_lsb : base bit of slice k in a vector of back-to-back w-bit fields
package regfile_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   localparam int MIN_RD = 1;
   localparam int MAX_RD = 4;

   function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
//   rd_addr : read address
//   mem     : current storage array contents
//   fwd_en  : a write is being accepted this cycle
//   wr_addr : address of that write
//   wr_data : data of that write
//   rd_data : read result (zero-reg, then forwarded write, then array)
module regfile_rd_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int DEPTH    = 1 << ADDR_W
) (
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem [DEPTH],
   input  logic              fwd_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   always_comb begin
      rd_data = mem[rd_addr];
      // write-first: a same-cycle write to this address wins over the array
      if (fwd_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end
      // the hardwired zero entry overrides even a forwarded write
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_RD combinational read
// ports, optional hardwired-zero entry 0, write-to-read forwarding and a
// software-triggered clear sweep that zeroes one entry per cycle.
//   clk      : clock
//   rst      : synchronous active-low reset, clears every entry
//   rd_addr  : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  : packed read data, port k at [k*DATA_W +: DATA_W]
//   wr_en    : write request
//   wr_addr  : write address
//   wr_data  : write data
//   wr_ready : writes are accepted this cycle (low during a sweep)
//   clr_req  : one-cycle pulse that starts a clear sweep
//   busy     : clear sweep in progress
//
// state    | meaning
// ST_IDLE  | normal operation, writes accepted, clr_req starts a sweep
// ST_SWEEP | clearing entry sweep_idx each cycle, writes and clr_req ignored
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_ready,
   input  logic                     clr_req,
   output logic                     busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   if ((NUM_RD < MIN_RD) || (NUM_RD > MAX_RD)) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be between 1 and 4");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            state;
   logic [ADDR_W-1:0] sweep_idx;
   logic              wr_acc;
   logic              wr_drop;

   // wr_ready is a registered copy of (state == ST_IDLE)
   assign wr_acc  = wr_en & wr_ready;
   assign wr_drop = (ZERO_REG != 0) && (wr_addr == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         sweep_idx <= '0;
         busy      <= 1'b0;
         wr_ready  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clr_req) begin
                  state     <= ST_SWEEP;
                  sweep_idx <= '0;
                  busy      <= 1'b1;
                  wr_ready  <= 1'b0;
               end
            end
            ST_SWEEP: begin
               // the index wraps to 0 on the same edge we return to idle
               sweep_idx <= sweep_idx + ADDR_W'(1);
               if (sweep_idx == LAST_IDX) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  wr_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               sweep_idx <= '0;
               busy      <= 1'b0;
               wr_ready  <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == ST_SWEEP) begin
         mem[sweep_idx] <= '0;
      end else if (wr_acc && !wr_drop) begin
         // a write coinciding with clr_req still lands; the sweep clears it later
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .DEPTH    (DEPTH)
      ) u_rd_port (
         .rd_addr (rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]),
         .mem     (mem),
         .fwd_en  (wr_acc),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_data (rd_data[slice_lsb(k, DATA_W) +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (2 ports, zero reg) and a
// 4-port instance without zero reg share the write/clear/reset stimulus.
module tb_regfile_mp;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [31:0]  wr_data;
   logic         clr_req;
   logic [9:0]   rd_addr_a;
   logic [63:0]  rd_data_a;
   logic         ready_a, busy_a;
   logic [19:0]  rd_addr_b;
   logic [127:0] rd_data_b;
   logic         ready_b, busy_b;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(ready_a), .clr_req(clr_req), .busy(busy_a));

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(ready_b), .clr_req(clr_req), .busy(busy_b));

   int total = 0;
   int bad   = 0;

   // reference model: two arrays plus "sweep in progress" and how far it got
   logic [31:0] m_a [32];
   logic [31:0] m_b [32];
   bit          m_busy;
   int          m_pos;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input bit zero_reg, input int a, input bit use_b);
      if (zero_reg && a == 0) return 32'h0;
      if (wr_en && !m_busy && int'(wr_addr) == a) return wr_data;
      return use_b ? m_b[a] : m_a[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_a[i] = 32'h0;
         m_b[i] = 32'h0;
      end
      m_busy = 1'b0;
      m_pos  = 0;
   endtask

   task automatic model_edge();
      if (!rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (wr_en) begin
            if (wr_addr != 5'd0) m_a[wr_addr] = wr_data;
            m_b[wr_addr] = wr_data;
         end
         if (clr_req) begin
            m_busy = 1'b1;
            m_pos  = 0;
         end
      end else begin
         m_a[m_pos] = 32'h0;
         m_b[m_pos] = 32'h0;
         if (m_pos == 31) m_busy = 1'b0;
         else m_pos++;
      end
   endtask

   // compare all outputs mid-cycle, then advance one clock
   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         chk("rd_a", rd_data_a[k*32 +: 32], exp_rd(1'b1, int'(rd_addr_a[k*5 +: 5]), 1'b0));
      for (int k = 0; k < 4; k++)
         chk("rd_b", rd_data_b[k*32 +: 32], exp_rd(1'b0, int'(rd_addr_b[k*5 +: 5]), 1'b1));
      chk("busy_a",  32'(busy_a),  32'(m_busy));
      chk("ready_a", 32'(ready_a), 32'(!m_busy));
      chk("busy_b",  32'(busy_b),  32'(m_busy));
      chk("ready_b", 32'(ready_b), 32'(!m_busy));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  ra0, ra1;
      logic [31:0] e0, e1;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int n;

      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
      rd_addr_a = '0; rd_addr_b = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b1;

      // reset state, every address on every port
      chk("rst_busy",  32'(busy_a),  32'h0);
      chk("rst_ready", 32'(ready_a), 32'h1);
      for (int a = 0; a < 32; a++) begin
         rd_addr_a = {5'(31 - a), 5'(a)};
         rd_addr_b = {5'(a), 5'(31 - a), 5'(a), 5'(31 - a)};
         #1;
         chk("rst_rd0", rd_data_a[31:0], 32'h0);
         chk("rst_rd1", rd_data_a[63:32], 32'h0);
         cycle();
      end

      // directed vectors on the zero-reg instance
      vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h0,        32'h0};
      vecs[1] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF};
      vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
      vecs[5] = '{1'b1, 5'd31, 32'h1,        5'd31, 5'd7,  32'h1,        32'hDEADBEEF};
      for (int i = 0; i < 6; i++) begin
         wr_en = vecs[i].wen; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
         rd_addr_a = {vecs[i].ra1, vecs[i].ra0};
         rd_addr_b = '0;
         #1;
         chk($sformatf("vec%0d_p0", i), rd_data_a[31:0],  vecs[i].e0);
         chk($sformatf("vec%0d_p1", i), rd_data_a[63:32], vecs[i].e1);
         if (i == 4) chk("noz_reg0", rd_data_b[31:0], 32'h12345678);
         cycle();
      end

      // four ports on one address while that address is being rewritten
      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hCAFEF00D; rd_addr_b = '0;
      cycle();
      wr_data = 32'h1; rd_addr_b = {4{5'd31}};
      #1;
      for (int k = 0; k < 4; k++) chk("mp_fwd", rd_data_b[k*32 +: 32], 32'h1);
      cycle();
      wr_en = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) chk("mp_hold", rd_data_b[k*32 +: 32], 32'h1);
      cycle();

      // fill 1..31 with their index, then sweep
      for (int r = 1; r < 32; r++) begin
         wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'(r);
         cycle();
      end
      wr_en = 1'b0; clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      n = 0;
      while (busy_a && n < 40) begin
         wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_0003;
         clr_req = (n == 15);
         rd_addr_a = (n == 10) ? {5'd20, 5'd5} : {5'(n), 5'd3};
         #1;
         if (n == 10) begin
            chk("sweep_r5",  rd_data_a[31:0],  32'h0);
            chk("sweep_r20", rd_data_a[63:32], 32'd20);
         end
         chk("sweep_ready", 32'(ready_a), 32'h0);
         cycle();
         n++;
      end
      chk("sweep_len", 32'(n), 32'd32);
      wr_en = 1'b0; clr_req = 1'b0; rd_addr_a = {5'd20, 5'd3};
      #1;
      chk("post_r3",  rd_data_a[31:0],  32'h0);
      chk("post_r20", rd_data_a[63:32], 32'h0);
      chk("post_busy", 32'(busy_a), 32'h0);
      cycle();

      // reset in the middle of a sweep
      for (int r = 1; r < 32; r++) begin
         wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'h100 + 32'(r);
         cycle();
      end
      wr_en = 1'b0; clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int c = 0; c < 12; c++) cycle();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      #1;
      chk("mid_rst_busy",  32'(busy_a),  32'h0);
      chk("mid_rst_ready", 32'(ready_a), 32'h1);
      for (int a = 0; a < 32; a++) begin
         rd_addr_a = {5'(a), 5'(a)};
         rd_addr_b = {4{5'(a)}};
         #1;
         chk("mid_rst_rd", rd_data_b[31:0], 32'h0);
         cycle();
      end
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
      cycle();
      wr_en = 1'b0; rd_addr_a = {5'd9, 5'd9};
      #1;
      chk("mid_rst_r9", rd_data_a[31:0], 32'hA5A5A5A5);
      cycle();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(199) != 0);
         wr_en     = 1'($urandom_range(1));
         wr_addr   = 5'($urandom_range(31));
         wr_data   = $urandom;
         clr_req   = ($urandom_range(39) == 0);
         rd_addr_a = 10'($urandom);
         // bias reads toward the write address so forwarding gets exercised
         if ($urandom_range(3) == 0) rd_addr_a[4:0] = wr_addr;
         rd_addr_b = 20'($urandom);
         if ($urandom_range(3) == 0) rd_addr_b[9:5] = wr_addr;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
